sub_seq: RTL and testbench

SUB_SEQ -- requirements
Module: sub_seq

---
 rtl/sub_seq_pkg.sv | 21 ++
 rtl/sub_chunk.sv | 19 +
 rtl/sub_seq.sv | 112 +++++++++++
 tb/tb_sub_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtractor.
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice counter width; a single-slice operand still gets a 1-bit counter.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// CHUNK-bit combinational subtract with borrow chain.
module sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] r;

    // The extra top bit goes to 1 exactly when a - b - bin underflows.
    assign r    = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    assign d    = r[CHUNK-1:0];
    assign bout = r[CHUNK];

endmodule

// File: rtl/sub_seq.sv
// Multi-cycle WIDTH-bit subtractor: one CHUNK slice per BUSY cycle, LSB first,
// with registered difference, unsigned borrow and signed overflow.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sub_i1,
    input  logic [WIDTH-1:0] sub_i2,
    input  logic             sub_valid_i,
    output logic             sub_ready_o,
    output logic [WIDTH-1:0] sub_o,
    output logic             sub_borrow_o,
    output logic             sub_ovf_o,
    output logic             sub_valid_o,
    input  logic             sub_ready_i
);

    localparam int            NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int            CW     = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST   = CW'(NCHUNK - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             bin_q;
    logic             fin;
    logic [CHUNK-1:0] a_sl, b_sl, d_sl;
    logic             bout;
    logic             in_xfer, out_xfer;

    assign a_sl = CHUNK'(a_q >> (int'(cnt) * CHUNK));
    assign b_sl = CHUNK'(b_q >> (int'(cnt) * CHUNK));

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (bin_q),
        .d    (d_sl),
        .bout (bout)
    );

    assign in_xfer  = sub_valid_i && sub_ready_o;
    assign out_xfer = sub_valid_o && sub_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // DONE accepts new operands only in the same cycle its result leaves.
    always_comb begin
        state_n     = state;
        sub_ready_o = 1'b0;
        case (state)
            IDLE: begin
                sub_ready_o = 1'b1;
                if (sub_valid_i) state_n = BUSY;
            end
            BUSY: begin
                if (fin) state_n = DONE;
            end
            DONE: begin
                sub_ready_o = sub_ready_i;
                if (sub_ready_i) state_n = sub_valid_i ? BUSY : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // After the last slice one more BUSY cycle folds the flags from the
    // registered difference, so flags and valid land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            bin_q        <= 1'b0;
            fin          <= 1'b0;
            sub_o        <= '0;
            sub_borrow_o <= 1'b0;
            sub_ovf_o    <= 1'b0;
            sub_valid_o  <= 1'b0;
        end else begin
            if (in_xfer) begin
                a_q   <= sub_i1;
                b_q   <= sub_i2;
                cnt   <= '0;
                bin_q <= 1'b0;
                fin   <= 1'b0;
            end else if (state == BUSY) begin
                if (!fin) begin
                    sub_o[int'(cnt)*CHUNK +: CHUNK] <= d_sl;
                    bin_q <= bout;
                    if (cnt == LAST) fin <= 1'b1;
                    else             cnt <= cnt + CW'(1);
                end else begin
                    sub_borrow_o <= bin_q;
                    sub_ovf_o    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (sub_o[WIDTH-1] != a_q[WIDTH-1]);
                end
            end

            if (state == BUSY && fin) sub_valid_o <= 1'b1;
            else if (out_xfer)        sub_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq: 64/16 instance against a transaction-level model,
// plus a single-slice 8/8 instance with literal expectations.
module tb_sub_seq;

    localparam int W = 64;
    localparam int C = 16;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sub_i1 = '0, sub_i2 = '0, sub_o;
    logic         sub_valid_i = 1'b0, sub_ready_i = 1'b1;
    logic         sub_ready_o, sub_borrow_o, sub_ovf_o, sub_valid_o;

    logic [7:0]   a8 = '0, b8 = '0, d8;
    logic         v8 = 1'b0, r8 = 1'b1, rdy8, bor8, ovf8, val8;

    always #5 clk = ~clk;

    sub_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .sub_i1(sub_i1), .sub_i2(sub_i2),
        .sub_valid_i(sub_valid_i), .sub_ready_o(sub_ready_o), .sub_o(sub_o),
        .sub_borrow_o(sub_borrow_o), .sub_ovf_o(sub_ovf_o),
        .sub_valid_o(sub_valid_o), .sub_ready_i(sub_ready_i)
    );

    sub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sub_i1(a8), .sub_i2(b8),
        .sub_valid_i(v8), .sub_ready_o(rdy8), .sub_o(d8),
        .sub_borrow_o(bor8), .sub_ovf_o(ovf8),
        .sub_valid_o(val8), .sub_ready_i(r8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {a < b, (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), d};
    endfunction

    logic         m_busy = 1'b0, m_valid = 1'b0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_bor = 1'b0, m_ovf = 1'b0, p_bor = 1'b0, p_ovf = 1'b0;
    int           cyc = 0, m_due = 0;
    logic         m_ready;

    assign m_ready = !m_busy && (!m_valid || sub_ready_i);

    // An accepted operation becomes visible N+1 edges after its transfer edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            cyc     <= 0;
            m_due   <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy && cyc == m_due) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                {m_bor, m_ovf, m_res} <= {p_bor, p_ovf, p_res};
            end else if (m_valid && sub_ready_i) begin
                m_valid <= 1'b0;
            end
            if (sub_valid_i && m_ready) begin
                m_busy <= 1'b1;
                m_due  <= cyc + N + 1;
                {p_bor, p_ovf, p_res} <= ref_sub(sub_i1, sub_i2);
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_o", {63'd0, sub_valid_o}, {63'd0, m_valid});
        chk("ready_o", {63'd0, sub_ready_o}, {63'd0, m_ready});
        if (m_valid) begin
            chk("sub_o", sub_o, m_res);
            chk("borrow", {63'd0, sub_borrow_o}, {63'd0, m_bor});
            chk("ovf", {63'd0, sub_ovf_o}, {63'd0, m_ovf});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("ready_before_issue", {63'd0, sub_ready_o}, 64'd1);
        sub_i1 = a;
        sub_i2 = b;
        sub_valid_i = 1'b1;
        @(posedge clk); #1;
        sub_valid_i = 1'b0;
        sub_i1 = {$urandom, $urandom};
        sub_i2 = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sub_valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        issue(a, b);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'(N + 1));
        chk("lit_sub_o", sub_o, ed);
        chk("lit_borrow", {63'd0, sub_borrow_o}, {63'd0, eb});
        chk("lit_ovf", {63'd0, sub_ovf_o}, {63'd0, eo});
        chk("model_pin", m_res, ed);
        @(posedge clk); #1;
        chk("valid_after_xfer", {63'd0, sub_valid_o}, 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        chk("rdy8_before", {63'd0, rdy8}, 64'd1);
        a8 = a;
        b8 = b;
        v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        a8 = 8'hA5;
        b8 = 8'h3C;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (val8) begin
                lat = i;
                break;
            end
        end
        chk("lat8", 64'(lat), 64'd2);
        chk("d8", {56'd0, d8}, {56'd0, ed});
        chk("bor8", {63'd0, bor8}, {63'd0, eb});
        chk("ovf8", {63'd0, ovf8}, {63'd0, eo});
        @(posedge clk); #1;
        chk("val8_after", {63'd0, val8}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int lat;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sub_o", sub_o, 64'd0);
        chk("rst_borrow", {63'd0, sub_borrow_o}, 64'd0);
        chk("rst_ovf", {63'd0, sub_ovf_o}, 64'd0);
        chk("rst_valid", {63'd0, sub_valid_o}, 64'd0);
        chk("rst_ready", {63'd0, sub_ready_o}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, sub_ready_o}, 64'd1);

        // basic values and boundary borrow/overflow cases
        run_op(64'd100, 64'd58, 64'd42, 1'b0, 1'b0);
        run_op(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b1, 1'b1);
        run_op(64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000,
               64'h0000_FFFF_FFFF_0000, 1'b0, 1'b0);

        // downstream stall in DONE, then back-to-back accept
        sub_ready_i = 1'b0;
        issue(64'd3, 64'd1);
        wait_valid(lat);
        chk("stall_latency", 64'(lat), 64'(N + 1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_sub_o", sub_o, 64'd2);
            chk("stall_valid", {63'd0, sub_valid_o}, 64'd1);
            chk("stall_ready", {63'd0, sub_ready_o}, 64'd0);
        end
        sub_i1 = 64'd10;
        sub_i2 = 64'd4;
        sub_valid_i = 1'b1;
        sub_ready_i = 1'b1;
        #1;
        chk("b2b_ready", {63'd0, sub_ready_o}, 64'd1);
        @(posedge clk); #1;
        sub_valid_i = 1'b0;
        chk("b2b_valid_drop", {63'd0, sub_valid_o}, 64'd0);
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'(N + 1));
        chk("b2b_sub_o", sub_o, 64'd6);
        @(posedge clk); #1;

        // reset in the middle of BUSY
        issue(64'd9, 64'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sub_o", sub_o, 64'd0);
        chk("abort_borrow", {63'd0, sub_borrow_o}, 64'd0);
        chk("abort_ovf", {63'd0, sub_ovf_o}, 64'd0);
        chk("abort_valid", {63'd0, sub_valid_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_ready", {63'd0, sub_ready_o}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {63'd0, sub_valid_o}, 64'd0);
        end

        // random operands, data checked by the model
        for (int i = 0; i < 6; i++) begin
            issue({$urandom, $urandom}, {$urandom, $urandom});
            wait_valid(lat);
            chk("rand_latency", 64'(lat), 64'(N + 1));
            @(posedge clk); #1;
        end

        // single-slice instance
        run8(8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
        run8(8'h07, 8'h05, 8'h02, 1'b0, 1'b0);
        run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
